// File: rtl/camera_frame_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// camera_frame_capture : single-clock camera capture (XCLK gen, PCLK oversample,
// pixel packing, decimation, frame RAM writes).   Rev 1.0
// ---------------------------------------------------------------------------
module camera_frame_capture #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_PIXELS        = 128,
  parameter int V_LINES         = 72,
  parameter int ADDR_W          = 15,
  parameter int XCLK_HALF       = 5,
  parameter int DECIM           = 1
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset,
  input  logic                                i_Enable,
  input  logic                                i_Single_Shot,
  output logic                                o_XLK,
  input  logic                                i_PLK,
  input  logic                                i_VS,
  input  logic                                i_HS,
  input  logic [DATA_W-1:0]                   i_D,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0]   o_RAM_Data,
  output logic [ADDR_W-1:0]                   o_RAM_Address,
  output logic                                o_RAM_Write_Enable,
  output logic                                o_Frame_Done,
  output logic                                o_Busy,
  output logic                                o_Error
);

  localparam int c_TOTAL  = H_PIXELS * V_LINES;
  localparam int c_PIX_W  = DATA_W * BYTES_PER_PIXEL;
  localparam int c_XCNT_W = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_CAPTURE} state_t;

  state_t              r_state, w_next;
  logic [c_XCNT_W-1:0] r_xclk_cnt;
  logic                r_plk_s1, r_plk_s2, r_plk_d;
  logic                r_vs_s1, r_vs_s2, r_vs_d;
  logic                r_hs_s1, r_hs_s2, r_hs_d;
  logic [DATA_W-1:0]   r_d_s1, r_d_s2, r_hi;
  logic [ADDR_W:0]     r_addr;
  logic                r_byte_ph, r_single, r_shot_done;
  logic [1:0]          r_col_ph, r_line_ph;
  logic                w_byte, w_vs_fall, w_vs_rise, w_hs_fall;
  logic                w_start, w_frame_end, w_capture, w_keep, w_room;
  logic [c_PIX_W-1:0]  w_pix;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    if (DECIM <= 1 || p == 2'(DECIM - 1)) return 2'd0;
    return p + 2'd1;
  endfunction

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_xclk_cnt <= '0;
      o_XLK      <= 1'b0;
    end else if (r_xclk_cnt == c_XCNT_W'(XCLK_HALF - 1)) begin
      r_xclk_cnt <= '0;
      o_XLK      <= ~o_XLK;
    end else begin
      r_xclk_cnt <= r_xclk_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      {r_plk_s1, r_plk_s2, r_plk_d} <= '0;
      {r_vs_s1, r_vs_s2, r_vs_d}    <= '0;
      {r_hs_s1, r_hs_s2, r_hs_d}    <= '0;
      r_d_s1 <= '0;
      r_d_s2 <= '0;
    end else begin
      {r_plk_s1, r_plk_s2, r_plk_d} <= {i_PLK, r_plk_s1, r_plk_s2};
      {r_vs_s1, r_vs_s2, r_vs_d}    <= {i_VS, r_vs_s1, r_vs_s2};
      {r_hs_s1, r_hs_s2, r_hs_d}    <= {i_HS, r_hs_s1, r_hs_s2};
      r_d_s1 <= i_D;
      r_d_s2 <= r_d_s1;
    end
  end

  // A byte is only accepted on a PCLK rise inside an active line outside VSYNC.
  assign w_byte    = r_plk_s2 & ~r_plk_d & r_hs_s2 & ~r_vs_s2;
  assign w_vs_fall = ~r_vs_s2 & r_vs_d;
  assign w_vs_rise = r_vs_s2 & ~r_vs_d;
  assign w_hs_fall = ~r_hs_s2 & r_hs_d;
  assign w_keep    = (r_col_ph == 2'd0) && (r_line_ph == 2'd0);
  assign w_room    = r_addr < (ADDR_W + 1)'(c_TOTAL);
  assign o_Busy    = (r_state != S_IDLE);

  generate
    if (BYTES_PER_PIXEL == 2) begin : g_pack2
      assign w_pix = {r_hi, r_d_s2};
    end else begin : g_pack1
      assign w_pix = r_d_s2;
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:       if (i_Enable && !r_shot_done) w_next = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (!i_Enable) begin
          w_next = S_IDLE;
        end else if (w_vs_fall) begin
          w_next  = S_CAPTURE;
          w_start = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        if (w_vs_rise) begin
          w_frame_end = 1'b1;
          w_next      = (r_single || !i_Enable) ? S_IDLE : S_WAIT_FRAME;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A finished single shot holds the block in IDLE until i_Enable is released.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_single    <= 1'b0;
      r_shot_done <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_WAIT_FRAME) r_single <= i_Single_Shot;
      if (!i_Enable)                                   r_shot_done <= 1'b0;
      else if (w_frame_end && r_single)                r_shot_done <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_addr             <= '0;
      r_byte_ph          <= 1'b0;
      r_col_ph           <= 2'd0;
      r_line_ph          <= 2'd0;
      r_hi               <= '0;
      o_RAM_Data         <= '0;
      o_RAM_Address      <= '0;
      o_RAM_Write_Enable <= 1'b0;
      o_Frame_Done       <= 1'b0;
      o_Error            <= 1'b0;
    end else begin
      o_RAM_Write_Enable <= 1'b0;
      o_Frame_Done       <= 1'b0;
      if (w_start) begin
        r_addr    <= '0;
        r_byte_ph <= 1'b0;
        r_col_ph  <= 2'd0;
        r_line_ph <= 2'd0;
      end else if (w_capture) begin
        if (w_hs_fall) begin
          r_byte_ph <= 1'b0;
          r_col_ph  <= 2'd0;
          r_line_ph <= next_phase(r_line_ph);
        end else if (w_byte) begin
          if (BYTES_PER_PIXEL == 2 && !r_byte_ph) begin
            r_hi      <= r_d_s2;
            r_byte_ph <= 1'b1;
          end else begin
            r_byte_ph <= 1'b0;
            r_col_ph  <= next_phase(r_col_ph);
            if (w_keep) begin
              if (w_room) begin
                o_RAM_Write_Enable <= 1'b1;
                o_RAM_Data         <= w_pix;
                o_RAM_Address      <= r_addr[ADDR_W-1:0];
                r_addr             <= r_addr + 1'b1;
              end else begin
                o_Error <= 1'b1;
              end
            end
          end
        end
        if (w_frame_end) begin
          o_Frame_Done <= 1'b1;
          if (r_addr != (ADDR_W + 1)'(c_TOTAL)) o_Error <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_frame_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_camera_frame_capture : scoreboard bench, DECIM=1 and DECIM=2 instances.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_camera_frame_capture;

  localparam int c_H = 4, c_V = 2, c_TOTAL = c_H * c_V, c_AW = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        en1 = 1'b0, en2 = 1'b0, single1 = 1'b0, single2 = 1'b0;
  logic        plk = 1'b0, vs = 1'b1, hs = 1'b0;
  logic [7:0]  d = 8'h00;
  logic        xlk1, we1, done1, busy1, err1;
  logic        xlk2, we2, done2, busy2, err2;
  logic [15:0] data1, data2;
  logic [3:0]  addr1, addr2;

  int n_vectors = 0, n_miscompares = 0;
  int wr_cnt1 = 0, wr_cnt2 = 0, done_cnt1 = 0, done_cnt2 = 0;
  logic [15:0] q1_data[$], q2_data[$];
  logic [3:0]  q1_addr[$], q2_addr[$];
  logic [15:0] m1_ed, m2_ed;
  logic [3:0]  m1_ea, m2_ea;

  always #5 clk = ~clk;

  camera_frame_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .H_PIXELS(c_H), .V_LINES(c_V),
                         .ADDR_W(c_AW), .XCLK_HALF(5), .DECIM(1)) u_dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en1), .i_Single_Shot(single1), .o_XLK(xlk1),
    .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d), .o_RAM_Data(data1), .o_RAM_Address(addr1),
    .o_RAM_Write_Enable(we1), .o_Frame_Done(done1), .o_Busy(busy1), .o_Error(err1));

  camera_frame_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .H_PIXELS(c_H), .V_LINES(c_V),
                         .ADDR_W(c_AW), .XCLK_HALF(5), .DECIM(2)) u_dut_d2 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en2), .i_Single_Shot(single2), .o_XLK(xlk2),
    .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d), .o_RAM_Data(data2), .o_RAM_Address(addr2),
    .o_RAM_Write_Enable(we2), .o_Frame_Done(done2), .o_Busy(busy2), .o_Error(err2));

  // Write monitors: every strobe is checked against the head of its scoreboard.
  always @(negedge clk) begin
    if (done1) done_cnt1++;
    if (we1) begin
      n_vectors++;
      wr_cnt1++;
      if (q1_data.size() == 0) begin
        n_miscompares++;
        $display("FAIL dut1_write: got addr=%0d data=%h, required no write", addr1, data1);
      end else begin
        m1_ed = q1_data.pop_front();
        m1_ea = q1_addr.pop_front();
        if (data1 !== m1_ed || addr1 !== m1_ea) begin
          n_miscompares++;
          $display("FAIL dut1_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   addr1, data1, m1_ea, m1_ed);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done2) done_cnt2++;
    if (we2) begin
      n_vectors++;
      wr_cnt2++;
      if (q2_data.size() == 0) begin
        n_miscompares++;
        $display("FAIL dut2_write: got addr=%0d data=%h, required no write", addr2, data2);
      end else begin
        m2_ed = q2_data.pop_front();
        m2_ea = q2_addr.pop_front();
        if (data2 !== m2_ed || addr2 !== m2_ea) begin
          n_miscompares++;
          $display("FAIL dut2_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   addr2, data2, m2_ea, m2_ed);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pclk_byte(input logic [7:0] b);
    d = b;
    repeat (4) @(negedge clk);
    plk = 1'b1;
    repeat (4) @(negedge clk);
    plk = 1'b0;
  endtask

  // Drives one frame; when exp is set, the expected writes are modelled here.
  task automatic drive_frame(input int n_lines, input int n_bytes, input int which,
                             input bit exp, input int decim);
    int b, addr;
    b = 0;
    addr = 0;
    repeat (8) @(negedge clk);
    vs = 1'b0;
    repeat (8) @(negedge clk);
    for (int l = 0; l < n_lines; l++) begin
      hs = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < n_bytes; i++) begin
        if (exp && (i % 2 == 1) && (l % decim == 0) && ((i / 2) % decim == 0) && addr < c_TOTAL) begin
          if (which == 1) begin
            q1_data.push_back({8'(b - 1), 8'(b)});
            q1_addr.push_back(4'(addr));
          end else begin
            q2_data.push_back({8'(b - 1), 8'(b)});
            q2_addr.push_back(4'(addr));
          end
          addr++;
        end
        pclk_byte(8'(b));
        b++;
      end
      repeat (4) @(negedge clk);
      hs = 1'b0;
      repeat (8) @(negedge clk);
    end
    vs = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q1_data.size() != 0 || q2_data.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_vectors++;
    if (q1_data.size() != 0 || q2_data.size() != 0) begin
      n_miscompares++;
      $display("FAIL %s_drain: got %0d/%0d writes outstanding, required 0/0",
               name, q1_data.size(), q2_data.size());
    end
  endtask

  task automatic test_reset();
    int rise0, rise1, fall0, c;
    bit prev, bad;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_vectors++;
    if ({xlk1, we1, done1, busy1, err1, data1, addr1} !== '0) begin
      n_miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", {xlk1, we1, done1, busy1, err1, data1, addr1});
    end
    rst = 1'b0;
    rise0 = -1; rise1 = -1; fall0 = -1; bad = 1'b0;
    prev = xlk1;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (xlk1 && !prev) begin
        if (rise0 < 0) rise0 = c;
        else if (rise1 < 0) rise1 = c;
      end
      if (!xlk1 && prev && rise0 >= 0 && fall0 < 0) fall0 = c;
      if ({we1, done1, busy1, err1, data1, addr1} !== '0) bad = 1'b1;
      prev = xlk1;
    end
    n_vectors++;
    if (rise1 - rise0 != 10) begin
      n_miscompares++;
      $display("FAIL xclk_period: got %0d, required 10", rise1 - rise0);
    end
    n_vectors++;
    if (fall0 - rise0 != 5) begin
      n_miscompares++;
      $display("FAIL xclk_high: got %0d, required 5", fall0 - rise0);
    end
    n_vectors++;
    if (bad) begin
      n_miscompares++;
      $display("FAIL idle_outputs: got nonzero, required 0");
    end
  endtask

  task automatic test_basic_frame();
    int w0, f0;
    w0 = wr_cnt1; f0 = done_cnt1;
    en1 = 1'b1;
    repeat (4) @(negedge clk);
    drive_frame(2, 8, 1, 1'b1, 1);
    wait_drain("basic");
    n_vectors++;
    if (wr_cnt1 - w0 != 8) begin
      n_miscompares++;
      $display("FAIL basic_writes: got %0d, required 8", wr_cnt1 - w0);
    end
    n_vectors++;
    if (done_cnt1 - f0 != 1) begin
      n_miscompares++;
      $display("FAIL basic_done: got %0d, required 1", done_cnt1 - f0);
    end
    n_vectors++;
    if (err1 !== 1'b0) begin
      n_miscompares++;
      $display("FAIL basic_error: got %b, required 0", err1);
    end
    en1 = 1'b0;
    repeat (6) @(negedge clk);
    n_vectors++;
    if (busy1 !== 1'b0) begin
      n_miscompares++;
      $display("FAIL basic_busy: got %b, required 0", busy1);
    end
  endtask

  task automatic test_decimation();
    int w0, f0;
    w0 = wr_cnt2; f0 = done_cnt2;
    en2 = 1'b1;
    repeat (4) @(negedge clk);
    drive_frame(4, 16, 2, 1'b1, 2);
    wait_drain("decim");
    n_vectors++;
    if (wr_cnt2 - w0 != 8) begin
      n_miscompares++;
      $display("FAIL decim_writes: got %0d, required 8", wr_cnt2 - w0);
    end
    n_vectors++;
    if (done_cnt2 - f0 != 1 || err2 !== 1'b0) begin
      n_miscompares++;
      $display("FAIL decim_done_err: got done=%0d err=%b, required done=1 err=0", done_cnt2 - f0, err2);
    end
    en2 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_short_frame();
    int w0, f0;
    w0 = wr_cnt1; f0 = done_cnt1;
    en1 = 1'b1;
    repeat (4) @(negedge clk);
    drive_frame(1, 8, 1, 1'b1, 1);
    wait_drain("short");
    n_vectors++;
    if (wr_cnt1 - w0 != 4 || done_cnt1 - f0 != 1) begin
      n_miscompares++;
      $display("FAIL short_counts: got writes=%0d done=%0d, required 4/1", wr_cnt1 - w0, done_cnt1 - f0);
    end
    n_vectors++;
    if (err1 !== 1'b1) begin
      n_miscompares++;
      $display("FAIL short_error: got %b, required 1", err1);
    end
    en1 = 1'b0;
    repeat (50) @(negedge clk);
    n_vectors++;
    if (err1 !== 1'b1) begin
      n_miscompares++;
      $display("FAIL short_error_sticky: got %b, required 1", err1);
    end
  endtask

  task automatic test_single_shot();
    int w0, f0;
    w0 = wr_cnt1; f0 = done_cnt1;
    single1 = 1'b1;
    en1 = 1'b1;
    repeat (4) @(negedge clk);
    drive_frame(2, 8, 1, 1'b1, 1);
    drive_frame(2, 8, 1, 1'b0, 1);
    wait_drain("single");
    n_vectors++;
    if (wr_cnt1 - w0 != 8 || done_cnt1 - f0 != 1) begin
      n_miscompares++;
      $display("FAIL single_counts: got writes=%0d done=%0d, required 8/1", wr_cnt1 - w0, done_cnt1 - f0);
    end
    n_vectors++;
    if (busy1 !== 1'b0) begin
      n_miscompares++;
      $display("FAIL single_busy: got %b, required 0", busy1);
    end
    en1 = 1'b0;
    single1 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int w0, f0;
    w0 = wr_cnt1; f0 = done_cnt1;
    en1 = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (8) @(negedge clk);
    hs = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        q1_data.push_back({8'(i - 1), 8'(i)});
        q1_addr.push_back(4'(i / 2));
      end
      pclk_byte(8'(i));
    end
    n_vectors++;
    if (wr_cnt1 - w0 != 3) begin
      n_miscompares++;
      $display("FAIL midrst_pre_writes: got %0d, required 3", wr_cnt1 - w0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pclk_byte(8'h06);
    pclk_byte(8'h07);
    repeat (4) @(negedge clk);
    hs = 1'b0;
    repeat (8) @(negedge clk);
    vs = 1'b1;
    repeat (16) @(negedge clk);
    n_vectors++;
    if (wr_cnt1 - w0 != 3 || done_cnt1 - f0 != 0) begin
      n_miscompares++;
      $display("FAIL midrst_aborted: got writes=%0d done=%0d, required 3/0", wr_cnt1 - w0, done_cnt1 - f0);
    end
    drive_frame(2, 8, 1, 1'b1, 1);
    wait_drain("midrst");
    n_vectors++;
    if (wr_cnt1 - w0 != 11 || err1 !== 1'b0) begin
      n_miscompares++;
      $display("FAIL midrst_restart: got writes=%0d err=%b, required 11/0", wr_cnt1 - w0, err1);
    end
    en1 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_decimation();
    test_short_frame();
    test_single_shot();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
